// File: rtl/thor_pkg.sv
// Core-wide constants shared by the front-end pipeline blocks.
package thor_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_REG = 32;
    localparam int unsigned ILEN    = 32;

    // Canonical NOP (addi x0, x0, 0).
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

endpackage : thor_pkg

// File: rtl/ring_ptr.sv
// Circular-buffer pointer advance by 0, 1 or 2 with natural power-of-two wrap.
module ring_ptr #(
    parameter int unsigned PTRW = 3
) (
    input  logic [PTRW-1:0] ptr_i,
    input  logic [1:0]      step_i,
    output logic [PTRW-1:0] ptr_o
);

    assign ptr_o = ptr_i + PTRW'(step_i);

endmodule : ring_ptr

// File: rtl/instruction_queue.sv
// Fetch-to-decode instruction buffer: 0/1/2 pushes per cycle, paired pops, flush.
module instruction_queue
    import thor_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTRW  = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            flush,
    input  logic [1:0]      pushCount,
    input  logic [ILEN-1:0] pushA,
    input  logic [ILEN-1:0] pushB,
    output logic            queueFull,
    input  logic            pop,
    output logic            queueEmpty,
    output logic [ILEN-1:0] insA,
    output logic [ILEN-1:0] insB,
    output logic [PTRW:0]   level
);

    localparam int unsigned CNTW    = PTRW + 1;
    localparam logic [CNTW-1:0] DEPTH_W = CNTW'(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instruction_queue: DEPTH must be a power of two >= 4");
    end

    logic [ILEN-1:0] mem_q [DEPTH];
    logic [ILEN-1:0] mem_d [DEPTH];
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0] count_q,  count_d;

    logic [CNTW-1:0] free_c;
    logic [1:0]      push_req_c;
    logic [1:0]      push_step_c;
    logic [1:0]      pop_step_c;
    logic            push_ok_c;
    logic            pop_ok_c;
    logic [PTRW-1:0] wr_adv_c;
    logic [PTRW-1:0] rd_adv_c;
    logic [PTRW-1:0] wr_ptr_p1_c;
    logic [PTRW-1:0] rd_ptr_p1_c;

    // Status is derived from pre-update state, so a same-cycle pop never frees room for a push.
    assign free_c     = DEPTH_W - count_q;
    assign queueEmpty = (count_q < CNTW'(2));
    assign queueFull  = (free_c < CNTW'(2));
    assign level      = count_q;

    assign push_req_c  = (pushCount == 2'd3) ? 2'd0 : pushCount;
    assign push_ok_c   = (push_req_c != 2'd0) && !queueFull && !flush;
    assign pop_ok_c    = pop && !queueEmpty && !flush;
    assign push_step_c = push_ok_c ? push_req_c : 2'd0;
    assign pop_step_c  = pop_ok_c ? 2'd2 : 2'd0;

    ring_ptr #(.PTRW(PTRW)) u_wr_adv (.ptr_i(wr_ptr_q), .step_i(push_step_c), .ptr_o(wr_adv_c));
    ring_ptr #(.PTRW(PTRW)) u_rd_adv (.ptr_i(rd_ptr_q), .step_i(pop_step_c),  .ptr_o(rd_adv_c));
    ring_ptr #(.PTRW(PTRW)) u_wr_p1  (.ptr_i(wr_ptr_q), .step_i(2'd1),        .ptr_o(wr_ptr_p1_c));
    ring_ptr #(.PTRW(PTRW)) u_rd_p1  (.ptr_i(rd_ptr_q), .step_i(2'd1),        .ptr_o(rd_ptr_p1_c));

    assign insA = mem_q[rd_ptr_q];
    assign insB = mem_q[rd_ptr_p1_c];

    // Pointer/count next state; flush wins over any concurrent push or pop.
    always_comb begin
        rd_ptr_d = rd_adv_c;
        wr_ptr_d = wr_adv_c;
        count_d  = count_q + CNTW'(push_step_c) - CNTW'(pop_step_c);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Storage write; contents survive a flush, only the pointers reset.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = pushA;
            if (push_req_c == 2'd2) begin
                mem_d[wr_ptr_p1_c] = pushB;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= NOP_INSTR;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule : instruction_queue

// File: tb/tb_instruction_queue.sv
// Randomized scoreboard bench for instruction_queue against a queue-based reference model.
module tb_instruction_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTRW  = 3;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        resetn;
    logic        flush;
    logic [1:0]  pushCount;
    logic [31:0] pushA;
    logic [31:0] pushB;
    logic        queueFull;
    logic        pop;
    logic        queueEmpty;
    logic [31:0] insA;
    logic [31:0] insB;
    logic [PTRW:0] level;

    instruction_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .pushCount(pushCount), .pushA(pushA), .pushB(pushB),
        .queueFull(queueFull), .pop(pop), .queueEmpty(queueEmpty),
        .insA(insA), .insB(insB), .level(level)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          lvl;
        bit          chk_a;
        bit          chk_b;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, record what the DUT should present now, then advance the model.
    task automatic cycle(input bit fl, input logic [1:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input bit pp);
        exp_t e;
        int   n;
        bit   room;
        bit   take;
        @(negedge clock);
        flush = fl; pushCount = pc; pushA = a; pushB = b; pop = pp;
        n = model.size();
        e.lvl   = n;
        e.chk_a = (n >= 1);
        e.chk_b = (n >= 2);
        e.a     = (n >= 1) ? model[0] : 32'h0;
        e.b     = (n >= 2) ? model[1] : 32'h0;
        sb.push_back(e);
        if (fl) begin
            model.delete();
        end else begin
            room = (int'(DEPTH) - n) >= 2;
            take = pp && (n >= 2);
            if (take) begin
                void'(model.pop_front());
                void'(model.pop_front());
            end
            if (room && pc == 2'd1) begin
                model.push_back(a);
            end else if (room && pc == 2'd2) begin
                model.push_back(a);
                model.push_back(b);
            end
        end
    endtask

    task automatic idle();
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: compare presented status and head instructions every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("level", 32'(level), 32'(e.lvl));
                check("queueEmpty", 32'(queueEmpty), 32'(e.lvl < 2));
                check("queueFull", 32'(queueFull), 32'((int'(DEPTH) - e.lvl) < 2));
                if (e.chk_a) check("insA", insA, e.a);
                if (e.chk_b) check("insB", insB, e.b);
            end
        end
    end

    initial begin
        resetn = 1'b0; flush = 1'b0; pushCount = 2'd0; pushA = '0; pushB = '0; pop = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        #1;
        check("reset_level", 32'(level), 32'd0);
        check("reset_empty", 32'(queueEmpty), 32'd1);
        check("reset_full", 32'(queueFull), 32'd0);
        check("reset_insA", insA, NOP);
        check("reset_insB", insB, NOP);

        // Double push then pop.
        cycle(1'b0, 2'd2, 32'h1111_1111, 32'h2222_2222, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        idle();

        // Single pushes, pop, then a pop with one held instruction.
        cycle(1'b0, 2'd1, 32'd1, 32'h0, 1'b0);
        cycle(1'b0, 2'd1, 32'd2, 32'h0, 1'b0);
        cycle(1'b0, 2'd1, 32'd3, 32'h0, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        idle();
        cycle(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);

        // Fill, dropped push while full, pop, simultaneous pop+push at level 6.
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'd2, 32'hA000_0000 + 32'(2*i), 32'hA000_0001 + 32'(2*i), 1'b0);
        cycle(1'b0, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b0, 2'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        cycle(1'b0, 2'd2, 32'hB000_0000, 32'hB000_0001, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

        // Wrap: odd write pointer then pairs straddling the last slot.
        cycle(1'b0, 2'd1, 32'hC000_0000, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd2, 32'hC100_0000 + 32'(i), 32'hC200_0000 + 32'(i), 1'b0);
        cycle(1'b0, 2'd1, 32'hC300_0000, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd2, 32'hC400_0000 + 32'(i), 32'hC500_0000 + 32'(i), 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);

        // Flush beats same-cycle pop and push at level 6.
        cycle(1'b1, 2'd0, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 2'd2, 32'hD000_0000 + 32'(i), 32'hD100_0000 + 32'(i), 1'b0);
        cycle(1'b1, 2'd2, 32'hEEEE_EEEE, 32'hFFFF_FFFF, 1'b1);
        idle();
        cycle(1'b0, 2'd1, 32'h1234_5678, 32'h0, 1'b0);
        cycle(1'b0, 2'd2, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 1'b0);
        idle();

        // Asynchronous reset between clock edges.
        @(negedge clock);
        #3;
        resetn = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_empty", 32'(queueEmpty), 32'd1);
        check("async_rst_insA", insA, NOP);
        check("async_rst_insB", insB, NOP);
        model.delete();
        @(negedge clock);
        resetn = 1'b1;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            bit fl;
            bit pp;
            logic [1:0] pc;
            fl = ($urandom_range(0, 39) == 0);
            pc = 2'($urandom_range(0, 3));
            pp = (i % 400 < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 6);
            cycle(fl, pc, $urandom, $urandom, pp);
        end
        idle();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
        #2;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instruction_queue
